fifo_tree_scheduler: RTL and testbench
======================================

Name: fifo_tree_scheduler

Overview:
- Sequences the clause FIFO tree used by the SAT clause pipeline.
- Arbitrates clause batches from NUM_REQ producers (round-robin) onto the tree's batch write port, spacing writes by the tree's multi-cycle ingest time.
- Tracks tree occupancy with credits to prevent overflow, handles overflow recovery, and drains the tree into a ready/valid consumer stream.

Parameters:
- NUM_REQ, 4, number of batch producers (≥2)
- CLAUSE_COUNT, 20, clauses per batch
- CLAUSE_WIDTH, 36, bits per clause
- BATCH_GAP, 5, cycles the tree needs to ingest one batch (wren cycle included)
- CREDIT_MAX, 32, maximum clauses allowed resident in the tree
- OCC_W, $clog2(CREDIT_MAX)+1, occupancy counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  producer k has a batch pending; held until granted
- req_clauses_i  in  NUM_REQ*CLAUSE_COUNT*CLAUSE_WIDTH  batch data, producer k at slice k
- req_valid_i  in  NUM_REQ*CLAUSE_COUNT  per-clause valid bits, producer k at slice k
- gnt_o  out  NUM_REQ  one-hot, 1-cycle pulse: batch captured
- tree_clauses_o  out  CLAUSE_COUNT*CLAUSE_WIDTH  registered batch to tree
- tree_valid_o  out  CLAUSE_COUNT  registered valid bits to tree
- tree_wren_o  out  1  tree write enable
- tree_rden_o  out  1  tree read enable
- tree_cof_o  out  1  tree clear-overflow pulse
- tree_empty_i  in  1  tree empty flag
- tree_of_i  in  1  tree overflow flag
- tree_clause_i  in  CLAUSE_WIDTH  tree output, valid the cycle after tree_rden_o
- cons_valid_o  out  1  output clause valid
- cons_clause_o  out  CLAUSE_WIDTH  output clause
- cons_ready_i  in  1  consumer accepts when valid&ready
- occupancy_o  out  OCC_W  clauses credited as resident in tree plus skid
- err_of_o  out  1  sticky overflow error
- err_clr_i  in  1  clears err_of_o
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async): all outputs 0; FSM=IDLE; RR pointer=0; occupancy=0; skid empty; in-flight flag 0.
- Write FSM:
  - IDLE: the RR winner is the first asserted req_i at or after the pointer, wrapping. Let P = popcount of the winner's valid bits. If occupancy+P ≤ CREDIT_MAX and err_of_o=0, then in the same cycle: gnt_o[winner]=1, capture data/valid into tree_* registers, occupancy += P, pointer = winner+1 mod NUM_REQ, next state LOAD. Otherwise no grant; lower-priority requesters are not skipped (no starvation).
  - LOAD: tree_wren_o=1 for exactly 1 cycle; next state HOLD.
  - HOLD: tree_clauses_o/tree_valid_o held stable for BATCH_GAP-1 cycles, then IDLE. Minimum grant-to-grant spacing is BATCH_GAP+1 cycles.
  - A batch with P=0 is still granted and written; occupancy is unchanged.
- Read path:
  - tree_rden_o=1 when ~tree_empty_i and (skid_count + inflight − pop) < 2. pop = cons_valid_o & cons_ready_i.
  - The cycle after a read, tree_clause_i is pushed into the 2-entry skid FIFO.
  - cons_valid_o = skid non-empty; cons_clause_o = skid head (FIFO order preserved).
  - occupancy −= 1 on each pop. Simultaneous grant and pop: occupancy += P−1.
  - The read path runs in every FSM state, including RECOVER.
- Overflow:
  - tree_of_i=1 sets err_of_o.
  - If seen in IDLE, go to RECOVER. If seen in LOAD/HOLD, finish HOLD first, then go to RECOVER.
  - RECOVER: tree_cof_o=1 for 1 cycle, then wait until tree_of_i=0, then IDLE. No grants while err_of_o=1.
  - err_clr_i clears err_of_o, except when tree_of_i=1 in the same cycle (set wins).
- Occupancy saturates at 0 (no underflow wrap); credit check arithmetic is performed at OCC_W+1 bits.
- busy_o = (state ≠ IDLE).

Test Plan:
- Reset, then req_i=4'b0001 with 20 valid clauses -> gnt_o=0001 at cycle 0; tree_wren_o at cycle 1 only; data stable cycles 1–5; occupancy=20; busy_o low at cycle 6.
- req_i=4'b1111 held, each batch 3 valid, consumer always ready -> grant order 0,1,2,3,0; grants spaced 6 cycles apart.
- occupancy=20, winner has 13 valid -> no grant (20+13 > 32), and no other requester is granted. After 1 pop (occupancy=19) the same winner is granted and occupancy=32.
- Tree non-empty with 5 clauses, cons_ready_i toggling 1,0,1,0 -> all 5 clauses delivered in order, none lost or duplicated; occupancy decrements only on handshake.
- tree_of_i pulsed during HOLD -> HOLD completes; one tree_cof_o pulse; err_of_o=1; no grants until err_clr_i; then normal grants resume.
- Assert reset mid-HOLD with skid full -> all outputs 0 immediately; occupancy=0; pointer=0.

Source files
------------

// File: rtl/fifo_tree_scheduler.sv
// Clause FIFO tree sequencer: round-robin batch writer with credit-based
// occupancy tracking, overflow recovery, and a 2-entry skid drain to a consumer.
module fifo_tree_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLAUSE_COUNT = 20,
  parameter int unsigned CLAUSE_WIDTH = 36,
  parameter int unsigned BATCH_GAP    = 5,
  parameter int unsigned CREDIT_MAX   = 32,
  parameter int unsigned OCC_W        = $clog2(CREDIT_MAX) + 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ*CLAUSE_COUNT*CLAUSE_WIDTH-1:0] req_clauses_i,
  input  logic [NUM_REQ*CLAUSE_COUNT-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]                     gnt_o,
  output logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0]   tree_clauses_o,
  output logic [CLAUSE_COUNT-1:0]                tree_valid_o,
  output logic                                   tree_wren_o,
  output logic                                   tree_rden_o,
  output logic                                   tree_cof_o,
  input  logic                                   tree_empty_i,
  input  logic                                   tree_of_i,
  input  logic [CLAUSE_WIDTH-1:0]                tree_clause_i,
  output logic                                   cons_valid_o,
  output logic [CLAUSE_WIDTH-1:0]                cons_clause_o,
  input  logic                                   cons_ready_i,
  output logic [OCC_W-1:0]                       occupancy_o,
  output logic                                   err_of_o,
  input  logic                                   err_clr_i,
  output logic                                   busy_o
);

  localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PopW     = $clog2(CLAUSE_COUNT + 1);
  localparam int unsigned GapW     = (BATCH_GAP > 2) ? $clog2(BATCH_GAP) : 1;
  localparam int unsigned HoldLast = (BATCH_GAP >= 2) ? BATCH_GAP - 2 : 0;
  localparam int unsigned BatchW   = CLAUSE_COUNT * CLAUSE_WIDTH;

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRecover, StRecWait} state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    err_q, err_d;
  logic                    of_pend_q, of_pend_d;
  logic [GapW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [CLAUSE_WIDTH-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
  logic [1:0]              skid_cnt_q, skid_cnt_d;
  logic                    inflight_q;
  logic [BatchW-1:0]       tree_clauses_q;
  logic [CLAUSE_COUNT-1:0] tree_valid_q;

  logic                    win_found;
  logic [PtrW-1:0]         win_idx, cand;
  logic [CLAUSE_COUNT-1:0] win_valid;
  logic [PopW-1:0]         win_pop;
  logic [OCC_W:0]          credit_sum, occ_sum;
  logic                    fits, grant, pop, end_of_write;
  logic [2:0]              level;

  // Round-robin winner: first pending request at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = PtrW'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_valid = req_valid_i[win_idx*CLAUSE_COUNT +: CLAUSE_COUNT];

  // Popcount of the winner's valid bits and the credit check at OCC_W+1 bits.
  always_comb begin
    win_pop = '0;
    for (int i = 0; i < int'(CLAUSE_COUNT); i++) begin
      win_pop = win_pop + PopW'(win_valid[i]);
    end
    credit_sum = {1'b0, occ_q} + (OCC_W+1)'(win_pop);
    fits       = (credit_sum <= (OCC_W+1)'(CREDIT_MAX));
  end

  // Grant only from IDLE; an overflow seen in IDLE takes priority over a grant.
  assign grant = !reset && (state_q == StIdle) && win_found && fits && !err_q && !tree_of_i;
  assign gnt_o = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign ptr_d = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Read issue: keep skid entries plus the in-flight read below two after this pop.
  always_comb begin
    pop         = (skid_cnt_q != 2'd0) && cons_ready_i;
    level       = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    tree_rden_o = !reset && !tree_empty_i && (level < 3'd2);
  end

  // Write FSM next state, including deferred overflow recovery after HOLD.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    of_pend_d    = of_pend_q;
    end_of_write = 1'b0;
    case (state_q)
      StIdle: begin
        if (tree_of_i) state_d = StRecover;
        else if (grant) state_d = StLoad;
      end
      StLoad: begin
        of_pend_d  = of_pend_q | tree_of_i;
        hold_cnt_d = '0;
        if (BATCH_GAP < 2) end_of_write = 1'b1;
        else state_d = StHold;
      end
      StHold: begin
        of_pend_d  = of_pend_q | tree_of_i;
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == GapW'(HoldLast)) end_of_write = 1'b1;
      end
      StRecover: state_d = StRecWait;
      StRecWait: begin
        if (!tree_of_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (end_of_write) begin
      state_d   = (of_pend_q | tree_of_i) ? StRecover : StIdle;
      of_pend_d = 1'b0;
    end
  end

  // Occupancy: add batch credit on grant, release one per consumer pop, floor at 0.
  always_comb begin
    occ_sum = {1'b0, occ_q} + (grant ? (OCC_W+1)'(win_pop) : '0);
    if (pop && (occ_sum != '0)) occ_sum = occ_sum - 1'b1;
    occ_d = OCC_W'(occ_sum);
  end

  // Overflow flag is sticky; a concurrent overflow beats the clear.
  assign err_d = tree_of_i | (err_q & !err_clr_i);

  // Skid FIFO update: tree data arrives the cycle after its read.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (skid_cnt_q == 2'd0) skid0_d = tree_clause_i;
        else skid1_d = tree_clause_i;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = tree_clause_i;
        end else begin
          skid0_d = skid1_q;
          skid1_d = tree_clause_i;
        end
      end
      default: ;
    endcase
  end

  // State, credit and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      occ_q          <= '0;
      err_q          <= 1'b0;
      of_pend_q      <= 1'b0;
      hold_cnt_q     <= '0;
      skid0_q        <= '0;
      skid1_q        <= '0;
      skid_cnt_q     <= '0;
      inflight_q     <= 1'b0;
      tree_clauses_q <= '0;
      tree_valid_q   <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      of_pend_q  <= of_pend_d;
      hold_cnt_q <= hold_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
      inflight_q <= tree_rden_o;
      if (grant) begin
        ptr_q          <= ptr_d;
        tree_clauses_q <= req_clauses_i[win_idx*BatchW +: BatchW];
        tree_valid_q   <= win_valid;
      end
    end
  end

  assign tree_clauses_o = tree_clauses_q;
  assign tree_valid_o   = tree_valid_q;
  assign tree_wren_o    = (state_q == StLoad);
  assign tree_cof_o     = (state_q == StRecover);
  assign busy_o         = (state_q != StIdle);
  assign cons_valid_o   = (skid_cnt_q != 2'd0);
  assign cons_clause_o  = skid0_q;
  assign occupancy_o    = occ_q;
  assign err_of_o       = err_q;

endmodule

// File: tb/tb_fifo_tree_scheduler.sv
// Bench for fifo_tree_scheduler: cycle-level reference model plus directed
// scenarios with literal expectations and a randomized soak.
module tb_fifo_tree_scheduler;
  localparam int NR = 4;
  localparam int CC = 20;
  localparam int CW = 36;
  localparam int BG = 5;
  localparam int CM = 32;
  localparam int OW = 6;
  localparam int LogN = 8192;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]       req_i;
  logic [NR*CC*CW-1:0] req_clauses_i;
  logic [NR*CC-1:0]    req_valid_i;
  logic [NR-1:0]       gnt_o;
  logic [CC*CW-1:0]    tree_clauses_o;
  logic [CC-1:0]       tree_valid_o;
  logic tree_wren_o, tree_rden_o, tree_cof_o, tree_empty_i, tree_of_i;
  logic [CW-1:0]       tree_clause_i;
  logic                cons_valid_o;
  logic [CW-1:0]       cons_clause_o;
  logic                cons_ready_i;
  logic [OW-1:0]       occupancy_o;
  logic err_of_o, err_clr_i, busy_o;

  fifo_tree_scheduler #(
    .NUM_REQ(NR), .CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW), .BATCH_GAP(BG), .CREDIT_MAX(CM)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_clauses_i(req_clauses_i),
    .req_valid_i(req_valid_i), .gnt_o(gnt_o), .tree_clauses_o(tree_clauses_o),
    .tree_valid_o(tree_valid_o), .tree_wren_o(tree_wren_o), .tree_rden_o(tree_rden_o),
    .tree_cof_o(tree_cof_o), .tree_empty_i(tree_empty_i), .tree_of_i(tree_of_i),
    .tree_clause_i(tree_clause_i), .cons_valid_o(cons_valid_o),
    .cons_clause_o(cons_clause_o), .cons_ready_i(cons_ready_i),
    .occupancy_o(occupancy_o), .err_of_o(err_of_o), .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Producers
  logic [CW-1:0] pd [NR][CC];
  logic [CC-1:0] pv [NR];
  logic [NR-1:0] pend;
  int            prod_mode; // 0: clear on grant, 1: refill with 3 valid, 2: random

  // Reference model state
  int            m_last_g, m_ptr, m_occ, m_rec, m_skid;
  bit            m_err, m_pend, m_infl;
  logic [CW-1:0] m_stream [$];
  logic [CC*CW-1:0] m_tdata;
  logic [CC-1:0] m_tvalid;

  // Tree environment and samples
  logic [CW-1:0] env_tree [$];
  logic [CW-1:0] got_q [$];
  logic          s_rden, s_wren;
  logic [NR-1:0] s_gnt;
  logic [CC*CW-1:0] s_tdata;
  logic [CC-1:0] s_tvalid;

  // Per-cycle logs for directed literal checks
  logic [NR-1:0] gnt_log [LogN];
  bit            wren_log [LogN];
  bit            busy_log [LogN];
  bit            cof_log [LogN];
  int            occ_log [LogN];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [CC*CW-1:0] act,
                       input logic [CC*CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < NR; k++) begin
      for (int i = 0; i < CC; i++) req_clauses_i[(k*CC+i)*CW +: CW] = pd[k][i];
      req_valid_i[k*CC +: CC] = pv[k];
    end
    req_i = pend;
  endtask

  // n >= 0: lowest n clauses valid; n < 0: random valid pattern (incl. empty and full)
  task automatic load(input int k, input int n);
    pend[k] = 1'b1;
    for (int i = 0; i < CC; i++) pd[k][i] = CW'({$urandom(), $urandom()});
    if (n >= 0) begin
      pv[k] = '0;
      for (int i = 0; i < n; i++) pv[k][i] = 1'b1;
    end else begin
      case ($urandom_range(0, 7))
        0: pv[k] = '0;
        1: pv[k] = '1;
        default: pv[k] = CC'($urandom() & $urandom());
      endcase
    end
  endtask

  task automatic model_reset();
    m_last_g = -100; m_ptr = 0; m_occ = 0; m_rec = 0; m_skid = 0;
    m_err = 0; m_pend = 0; m_infl = 0;
    m_stream.delete();
    m_tdata = '0; m_tvalid = '0;
  endtask

  // Asynchronous reset with an immediate all-zero output check.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_wren", tree_wren_o, 0);
    chk("rst_rden", tree_rden_o, 0);
    chk("rst_cof", tree_cof_o, 0);
    chk("rst_cvalid", cons_valid_o, 0);
    chk("rst_cclause", cons_clause_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_err", err_of_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tvalid", tree_valid_o, 0);
    chk_w("rst_tdata", tree_clauses_o, '0);
    model_reset();
    env_tree.delete();
    pend = '0; pack();
    tree_empty_i = 1'b1; tree_of_i = 1'b0; err_clr_i = 1'b0; cons_ready_i = 1'b0;
    tree_clause_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: compare at negedge, advance model, then update environment.
  task automatic step();
    bit writing, idle, pop, e_rden;
    int win, p, k;
    logic [NR-1:0] e_gnt;
    @(negedge clk);
    writing = (cyc - m_last_g >= 1) && (cyc - m_last_g <= BG);
    idle    = !writing && (m_rec == 0);
    e_gnt = '0; win = -1; p = 0;
    if (idle && !tree_of_i && !m_err) begin
      for (int i = 0; i < NR; i++) begin
        k = (m_ptr + i) % NR;
        if (win < 0 && req_i[k]) win = k;
      end
    end
    if (win >= 0) begin
      p = $countones(pv[win]);
      if (m_occ + p <= CM) e_gnt[win] = 1'b1;
    end
    pop    = (m_skid > 0) && cons_ready_i;
    e_rden = !tree_empty_i && (m_skid + int'(m_infl) - int'(pop) < 2);

    chk("gnt", gnt_o, e_gnt);
    chk("wren", tree_wren_o, cyc == m_last_g + 1);
    chk("busy", busy_o, !idle);
    chk("cof", tree_cof_o, m_rec == 1);
    chk("rden", tree_rden_o, e_rden);
    chk("cvalid", cons_valid_o, m_skid > 0);
    chk("occ", occupancy_o, m_occ);
    chk("err", err_of_o, m_err);
    chk("tvalid", tree_valid_o, m_tvalid);
    chk_w("tdata", tree_clauses_o, m_tdata);
    if (m_skid > 0 && m_stream.size() > 0) chk("cclause", cons_clause_o, m_stream[0]);

    if (cyc < LogN) begin
      gnt_log[cyc] = gnt_o; wren_log[cyc] = tree_wren_o; busy_log[cyc] = busy_o;
      cof_log[cyc] = tree_cof_o; occ_log[cyc] = int'(occupancy_o);
    end
    s_rden = tree_rden_o; s_wren = tree_wren_o; s_gnt = gnt_o;
    s_tdata = tree_clauses_o; s_tvalid = tree_valid_o;
    if (cons_valid_o && cons_ready_i) got_q.push_back(cons_clause_o);

    if (e_gnt != '0) begin
      m_last_g = cyc; m_ptr = (win + 1) % NR; m_occ += p; m_tvalid = pv[win];
      for (int i = 0; i < CC; i++) begin
        m_tdata[i*CW +: CW] = pd[win][i];
        if (pv[win][i]) m_stream.push_back(pd[win][i]);
      end
    end
    if (pop) begin
      if (m_stream.size() > 0) m_stream.delete(0);
      if (m_occ > 0) m_occ--;
    end
    m_skid = m_skid + int'(m_infl) - int'(pop);
    m_infl = e_rden;
    if (m_rec == 1) m_rec = 2;
    else if (m_rec == 2) begin
      if (!tree_of_i) m_rec = 0;
    end else if (idle) begin
      if (tree_of_i) m_rec = 1;
    end else if (writing) begin
      if (tree_of_i) m_pend = 1;
      if (cyc - m_last_g == BG) begin
        if (m_pend) m_rec = 1;
        m_pend = 0;
      end
    end
    if (tree_of_i) m_err = 1;
    else if (err_clr_i) m_err = 0;
    cyc++;

    @(posedge clk);
    #1;
    if (s_rden && env_tree.size() > 0) tree_clause_i = env_tree.pop_front();
    else tree_clause_i = CW'({$urandom(), $urandom()});
    if (s_wren) begin
      for (int i = 0; i < CC; i++) if (s_tvalid[i]) env_tree.push_back(s_tdata[i*CW +: CW]);
    end
    tree_empty_i = (env_tree.size() == 0);
    for (int j = 0; j < NR; j++) begin
      if (s_gnt[j]) begin
        pend[j] = 1'b0;
        if (prod_mode == 1) load(j, 3);
      end
      if (prod_mode == 2 && !pend[j] && $urandom_range(0, 3) == 0) load(j, -1);
    end
    pack();
  endtask

  function automatic int count_gnt(input int from, input int to);
    int n = 0;
    for (int i = from; i < to && i < LogN; i++) if (gnt_log[i] != '0) n++;
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, ng, n_cof;
    int gcyc [5];
    int gwin [5];
    logic [CW-1:0] exp_d [5];
    for (int k = 0; k < NR; k++) begin
      pv[k] = '0;
      for (int i = 0; i < CC; i++) pd[k][i] = '0;
    end
    pend = '0; prod_mode = 0; reset = 1'b0; pack();
    tree_empty_i = 1'b1; tree_of_i = 1'b0; err_clr_i = 1'b0; cons_ready_i = 1'b0;
    tree_clause_i = '0;
    #3;
    do_reset();

    // A: single full batch, timing of grant/write/hold
    load(0, 20); pack();
    c0 = cyc;
    repeat (8) step();
    chk("A_gnt0", gnt_log[c0], 4'b0001);
    chk("A_wren_c0", wren_log[c0], 0);
    chk("A_wren_c1", wren_log[c0+1], 1);
    chk("A_wren_c2", wren_log[c0+2], 0);
    chk("A_busy_c5", busy_log[c0+5], 1);
    chk("A_busy_c6", busy_log[c0+6], 0);
    chk("A_occ_c6", occ_log[c0+6], 20);
    cons_ready_i = 1'b1;
    repeat (30) step();
    chk("A_drained", occupancy_o, 0);

    // B: four producers always requesting, round-robin and spacing
    do_reset();
    prod_mode = 1; cons_ready_i = 1'b1;
    for (int k = 0; k < NR; k++) load(k, 3);
    pack();
    c0 = cyc;
    repeat (32) step();
    ng = 0;
    for (int i = c0; i < cyc; i++) begin
      if (gnt_log[i] != '0 && ng < 5) begin
        gcyc[ng] = i;
        gwin[ng] = $clog2(int'(gnt_log[i]));
        ng++;
      end
    end
    chk("B_ngrants", ng, 5);
    chk("B_first_at_c0", gcyc[0] - c0, 0);
    for (int i = 0; i < 5; i++) chk("B_order", gwin[i], i % NR);
    for (int i = 1; i < 5; i++) chk("B_spacing", gcyc[i] - gcyc[i-1], 6);
    prod_mode = 0;

    // C: credit limit blocks the winner without skipping to others
    do_reset();
    load(0, 20); pack();
    repeat (10) step();
    load(1, 13); load(2, 1); pack();
    c1 = cyc;
    repeat (6) step();
    chk("C_blocked", count_gnt(c1, cyc), 0);
    chk("C_occ20", occupancy_o, 20);
    cons_ready_i = 1'b1;
    step();
    cons_ready_i = 1'b0;
    c2 = cyc;
    repeat (3) step();
    chk("C_gnt1", gnt_log[c2], 4'b0010);
    chk("C_occ32", occ_log[c2+1], 32);

    // D: five clauses drained with a toggling consumer
    do_reset();
    pend[0] = 1'b1; pv[0] = '0;
    for (int i = 0; i < CC; i++) pd[0][i] = 36'h5_0000_0000 + 36'(i);
    pv[0][0] = 1'b1; pv[0][3] = 1'b1; pv[0][7] = 1'b1; pv[0][12] = 1'b1; pv[0][19] = 1'b1;
    pack();
    exp_d[0] = 36'h5_0000_0000; exp_d[1] = 36'h5_0000_0003; exp_d[2] = 36'h5_0000_0007;
    exp_d[3] = 36'h5_0000_000c; exp_d[4] = 36'h5_0000_0013;
    repeat (10) step();
    chk("D_occ5", occupancy_o, 5);
    got_q.delete();
    for (int j = 0; j < 12; j++) begin
      cons_ready_i = (j % 2 == 0);
      step();
    end
    chk("D_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("D_data", got_q[i], exp_d[i]);
    chk("D_occ0", occupancy_o, 0);

    // E: overflow during HOLD, recovery, no grants until cleared
    do_reset();
    cons_ready_i = 1'b1;
    load(0, 2); load(1, 2); pack();
    c0 = cyc;
    repeat (3) step();
    tree_of_i = 1'b1;
    step();
    tree_of_i = 1'b0;
    repeat (12) step();
    chk("E_err", err_of_o, 1);
    chk("E_busy_hold_end", busy_log[c0+5], 1);
    chk("E_cof_c6", cof_log[c0+6], 1);
    n_cof = 0;
    for (int i = c0; i < cyc; i++) if (cof_log[i]) n_cof++;
    chk("E_one_cof", n_cof, 1);
    chk("E_no_gnt", count_gnt(c0 + 1, cyc), 0);
    err_clr_i = 1'b1;
    c1 = cyc;
    step();
    err_clr_i = 1'b0;
    repeat (2) step();
    chk("E_resume", gnt_log[c1+1], 4'b0010);

    // F: reset mid-HOLD with a full skid
    do_reset();
    load(0, 20); pack();
    repeat (5) step();
    chk("F_skid_full", cons_valid_o, 1);
    chk("F_busy", busy_o, 1);
    #2;
    do_reset();
    for (int k = 0; k < NR; k++) load(k, 1);
    pack();
    c1 = cyc;
    repeat (2) step();
    chk("F_ptr0", gnt_log[c1], 4'b0001);

    // Randomized soak against the model
    do_reset();
    prod_mode = 2;
    for (int j = 0; j < 1500; j++) begin
      cons_ready_i = ($urandom_range(0, 3) != 0);
      err_clr_i    = ($urandom_range(0, 15) == 0);
      tree_of_i    = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
